// File: rtl/hazard_forward_scoreboard.sv
// hazard_forward_scoreboard: EXE/MEM/WB destination shadow giving per-operand forward selects, stall and stall count.
// Macro HAZARD_FWD_EN enables forwarding with load-use-only stalls; undefined stalls on any EXE/MEM producer.
module hazard_forward_scoreboard #(
    parameter int REG_AW  = 4,
    parameter int NUM_SRC = 3,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_dest,
    input  logic                      id_wb_en,
    input  logic                      id_mem_rd,
    input  logic                      flush,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      hazard_stall,
    output logic [CNT_W-1:0]          stall_cnt
);
    logic                      exe_valid, exe_wb_en, exe_mem_rd, mem_valid, mem_wb_en, wb_valid, wb_wb_en;
    logic [REG_AW-1:0]         exe_dest, mem_dest, wb_dest;
    logic [NUM_SRC*REG_AW-1:0] exe_src;
    logic [NUM_SRC-1:0]        exe_src_used, hit_exe, hit_mem;
    logic                      take;
    logic                      unused_state;

    assign take = !flush && !hazard_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_valid    <= 1'b0;
            exe_wb_en    <= 1'b0;
            exe_mem_rd   <= 1'b0;
            exe_dest     <= '0;
            exe_src      <= '0;
            exe_src_used <= '0;
            mem_valid    <= 1'b0;
            mem_wb_en    <= 1'b0;
            mem_dest     <= '0;
            wb_valid     <= 1'b0;
            wb_wb_en     <= 1'b0;
            wb_dest      <= '0;
            stall_cnt    <= '0;
        end else begin
            wb_valid     <= mem_valid;
            wb_wb_en     <= mem_wb_en;
            wb_dest      <= mem_dest;
            mem_valid    <= exe_valid;
            mem_wb_en    <= exe_wb_en;
            mem_dest     <= exe_dest;
            exe_valid    <= take && id_valid;
            exe_wb_en    <= take && id_wb_en;
            exe_mem_rd   <= take && id_mem_rd;
            exe_dest     <= take ? id_dest : '0;
            exe_src      <= take ? id_src : '0;
            exe_src_used <= take ? id_src_used : '0;
            if (hazard_stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_src
            logic [REG_AW-1:0] id_s;
            assign id_s       = id_src[g*REG_AW +: REG_AW];
            assign hit_exe[g] = id_src_used[g] && id_s == exe_dest;
            assign hit_mem[g] = id_src_used[g] && id_s == mem_dest;
`ifdef HAZARD_FWD_EN
            logic [REG_AW-1:0] ex_s;
            assign ex_s = exe_src[g*REG_AW +: REG_AW];
            // MEM holds the younger producer, so it is checked before WB
            assign fwd_sel[2*g +: 2] = !(exe_valid && exe_src_used[g]) ? 2'b00 :
                                       (mem_valid && mem_wb_en && mem_dest == ex_s) ? 2'b01 :
                                       (wb_valid && wb_wb_en && wb_dest == ex_s) ? 2'b10 : 2'b00;
`else
            assign fwd_sel[2*g +: 2] = 2'b00;
`endif
        end
    endgenerate

`ifdef HAZARD_FWD_EN
    assign hazard_stall = !flush && id_valid && exe_valid && exe_wb_en && exe_mem_rd && |hit_exe;
    assign unused_state = ^hit_mem;
`else
    // WB needs no stall: the register file writes before it reads
    assign hazard_stall = !flush && id_valid &&
                          ((exe_valid && exe_wb_en && |hit_exe) || (mem_valid && mem_wb_en && |hit_mem));
    assign unused_state = ^{exe_src, exe_src_used, exe_mem_rd, wb_valid, wb_wb_en, wb_dest};
`endif
endmodule

// File: tb/tb_hazard_forward_scoreboard.sv
// tb_hazard_forward_scoreboard: directed and random stimulus against a stage-record model of the scoreboard.
// A second instance with CNT_W=2 checks counter saturation.
module tb_hazard_forward_scoreboard;
    typedef struct packed {
        logic        v;
        logic [3:0]  dest;
        logic        wb;
        logic        ld;
        logic [11:0] src;
        logic [2:0]  used;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0, id_wb_en = 1'b0, id_mem_rd = 1'b0, flush = 1'b0;
    logic [11:0] id_src = '0;
    logic [2:0]  id_src_used = '0;
    logic [3:0]  id_dest = '0;
    logic [5:0]  fwd_sel, fwd_sel2;
    logic        hazard_stall, hazard_stall2;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;

    rec_t        st[3];
    int          m_cnt = 0;
    logic [5:0]  exp_fwd;
    logic        exp_stall;
    logic [15:0] exp_cnt;
    logic [1:0]  exp_cnt2;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    hazard_forward_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_rd(id_mem_rd), .flush(flush),
        .fwd_sel(fwd_sel), .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
    );

    hazard_forward_scoreboard #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_rd(id_mem_rd), .flush(flush),
        .fwd_sel(fwd_sel2), .hazard_stall(hazard_stall2), .stall_cnt(stall_cnt2)
    );

    function automatic logic writes(rec_t r, logic [3:0] x);
        return r.v && r.wb && r.dest == x;
    endfunction

    function automatic rec_t ins(logic v, logic [3:0] d, logic wb, logic ld,
                                 logic [3:0] s0, logic [3:0] s1, logic [3:0] s2, logic [2:0] used);
        return '{v: v, dest: d, wb: wb, ld: ld, src: {s2, s1, s0}, used: used};
    endfunction

    task automatic apply(rec_t r, logic fl);
        id_valid = r.v; id_dest = r.dest; id_wb_en = r.wb; id_mem_rd = r.ld;
        id_src = r.src; id_src_used = r.used; flush = fl;
    endtask

    task automatic rand_inputs(int maxreg);
        id_valid = $urandom_range(0, 7) != 0;
        for (int i = 0; i < 3; i++) id_src[i*4 +: 4] = 4'($urandom_range(0, maxreg));
        id_src_used = 3'($urandom);
        id_dest = 4'($urandom_range(0, maxreg));
        id_wb_en = $urandom_range(0, 3) != 0;
        id_mem_rd = $urandom_range(0, 2) == 0;
        flush = $urandom_range(0, 7) == 0;
    endtask

    // Expected outputs from the current stage records and ID inputs
    task automatic evaluate();
        exp_fwd = '0;
        exp_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [3:0] s, d;
            s = st[0].src[i*4 +: 4];
            d = id_src[i*4 +: 4];
`ifdef HAZARD_FWD_EN
            if (st[0].v && st[0].used[i])
                exp_fwd[2*i +: 2] = writes(st[1], s) ? 2'b01 : writes(st[2], s) ? 2'b10 : 2'b00;
            if (id_src_used[i] && st[0].ld && writes(st[0], d)) exp_stall = 1'b1;
`else
            if (id_src_used[i] && (writes(st[0], d) || writes(st[1], d))) exp_stall = 1'b1;
`endif
        end
        if (flush || !id_valid || !rst) exp_stall = 1'b0;
        if (!rst) exp_fwd = '0;
        exp_cnt = m_cnt > 65535 ? 16'hffff : 16'(m_cnt);
        exp_cnt2 = m_cnt > 3 ? 2'd3 : 2'(m_cnt);
    endtask

    // Advance one clock: model shifts records and counts stalls, returning at the next falling edge
    task automatic tick();
        evaluate();
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 3; i++) st[i] = '0;
            m_cnt = 0;
        end else begin
            if (exp_stall) m_cnt++;
            st[2] = st[1];
            st[1] = st[0];
            st[0] = (!flush && !exp_stall) ? rec_t'{id_valid, id_dest, id_wb_en, id_mem_rd, id_src, id_src_used} : '0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            rand_inputs(15);
            #1;
            total++; if (fwd_sel !== 6'd0 || hazard_stall !== 1'b0) begin bad++; $display("FAIL reset_out c=%0d fwd=%b stall=%b want 0/0", c, fwd_sel, hazard_stall); end
            total++; if (stall_cnt !== 16'd0 || stall_cnt2 !== 2'd0) begin bad++; $display("FAIL reset_cnt c=%0d cnt=%0d cnt2=%0d want 0", c, stall_cnt, stall_cnt2); end
            tick();
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rand_inputs(15);
            id_valid = 1'b0;
            #1;
            total++; if (fwd_sel !== 6'd0 || hazard_stall !== 1'b0 || stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_hold c=%0d fwd=%b stall=%b cnt=%0d want 0", c, fwd_sel, hazard_stall, stall_cnt); end
            tick();
        end
    endtask

    task automatic test_forward();
        rec_t prog[2];
        int k = 0;
        prog[0] = ins(1, 3, 1, 0, 1, 2, 0, 3'b011);
        prog[1] = ins(1, 6, 1, 0, 3, 0, 0, 3'b001);
        for (int c = 0; c < 7; c++) begin
            apply(k < 2 ? prog[k] : rec_t'('0), 1'b0);
            #1; evaluate();
            total++; if (fwd_sel !== exp_fwd) begin bad++; $display("FAIL fwd_basic c=%0d fwd=%b want %b", c, fwd_sel, exp_fwd); end
            total++; if (hazard_stall !== exp_stall) begin bad++; $display("FAIL fwd_stall c=%0d stall=%b want %b", c, hazard_stall, exp_stall); end
`ifdef HAZARD_FWD_EN
            if (c == 2) begin
                total++; if (fwd_sel[1:0] !== 2'b01) begin bad++; $display("FAIL fwd_mem_src1 fwd=%b want 01", fwd_sel[1:0]); end
            end
`endif
            if (!exp_stall && k < 2) k++;
            tick();
        end
    endtask

    task automatic test_mem_priority();
        rec_t prog[3];
        int k = 0;
        prog[0] = ins(1, 5, 1, 0, 0, 0, 0, 3'b000);
        prog[1] = ins(1, 5, 1, 0, 0, 0, 0, 3'b000);
        prog[2] = ins(1, 9, 1, 0, 1, 5, 2, 3'b010);
        for (int c = 0; c < 8; c++) begin
            apply(k < 3 ? prog[k] : rec_t'('0), 1'b0);
            #1; evaluate();
            total++; if (fwd_sel !== exp_fwd) begin bad++; $display("FAIL prio_fwd c=%0d fwd=%b want %b", c, fwd_sel, exp_fwd); end
            total++; if (hazard_stall !== exp_stall) begin bad++; $display("FAIL prio_stall c=%0d stall=%b want %b", c, hazard_stall, exp_stall); end
`ifdef HAZARD_FWD_EN
            if (c == 3) begin
                total++; if (fwd_sel[3:2] !== 2'b01) begin bad++; $display("FAIL prio_mem_wins fwd=%b want 01", fwd_sel[3:2]); end
            end
`endif
            if (!exp_stall && k < 3) k++;
            tick();
        end
    endtask

    task automatic test_load_use();
        rec_t prog[2];
        int k = 0;
        prog[0] = ins(1, 2, 1, 1, 0, 0, 0, 3'b000);
        prog[1] = ins(1, 7, 1, 0, 2, 1, 0, 3'b001);
        for (int c = 0; c < 7; c++) begin
            apply(k < 2 ? prog[k] : rec_t'('0), 1'b0);
            #1; evaluate();
            total++; if (fwd_sel !== exp_fwd) begin bad++; $display("FAIL lu_fwd c=%0d fwd=%b want %b", c, fwd_sel, exp_fwd); end
            total++; if (hazard_stall !== exp_stall) begin bad++; $display("FAIL lu_stall c=%0d stall=%b want %b", c, hazard_stall, exp_stall); end
            total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL lu_cnt c=%0d cnt=%0d want %0d", c, stall_cnt, exp_cnt); end
            if (c == 1) begin
                total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL lu_first_stall stall=%b want 1", hazard_stall); end
            end
            if (!exp_stall && k < 2) k++;
            tick();
        end
    endtask

    task automatic test_flush();
        rec_t prog[2];
        int k = 0;
        prog[0] = ins(1, 2, 1, 1, 0, 0, 0, 3'b000);
        prog[1] = ins(1, 7, 1, 0, 0, 2, 0, 3'b010);
        for (int c = 0; c < 7; c++) begin
            apply(k < 2 ? prog[k] : rec_t'('0), c == 1);
            #1; evaluate();
            total++; if (fwd_sel !== exp_fwd) begin bad++; $display("FAIL fl_fwd c=%0d fwd=%b want %b", c, fwd_sel, exp_fwd); end
            total++; if (hazard_stall !== exp_stall) begin bad++; $display("FAIL fl_stall c=%0d stall=%b want %b", c, hazard_stall, exp_stall); end
            total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL fl_cnt c=%0d cnt=%0d want %0d", c, stall_cnt, exp_cnt); end
            if (c == 1) begin
                total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL fl_wins stall=%b want 0", hazard_stall); end
            end
            if (!exp_stall && k < 2 && c != 1) k++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        apply(ins(1, 2, 1, 1, 0, 0, 0, 3'b000), 1'b0);
        tick();
        apply(ins(1, 7, 1, 0, 0, 0, 2, 3'b100), 1'b0);
        #1;
        total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL mid_pre stall=%b want 1", hazard_stall); end
        rst = 1'b0;
        #1;
        total++; if (hazard_stall !== 1'b0 || stall_cnt !== 16'd0 || fwd_sel !== 6'd0) begin bad++; $display("FAIL mid_reset stall=%b cnt=%0d fwd=%b want 0", hazard_stall, stall_cnt, fwd_sel); end
        tick();
        rst = 1'b1;
        apply('0, 1'b0);
        tick();
    endtask

    task automatic test_saturate();
        rec_t prog[3];
        prog[0] = ins(1, 2, 1, 1, 0, 0, 0, 3'b000);
        prog[1] = ins(1, 8, 1, 0, 2, 0, 0, 3'b001);
        prog[2] = '0;
        for (int p = 0; p < 5; p++) begin
            int k = 0;
            int guard = 0;
            while (k < 3 && guard < 20) begin
                apply(prog[k], 1'b0);
                #1; evaluate();
                total++; if (hazard_stall !== exp_stall) begin bad++; $display("FAIL sat_stall p=%0d stall=%b want %b", p, hazard_stall, exp_stall); end
                if (!exp_stall) k++;
                guard++;
                tick();
            end
            if (k < 3) begin total++; bad++; $display("FAIL sat_timeout p=%0d k=%0d want 3", p, k); end
        end
        #1;
        total++; if (stall_cnt2 !== 2'd3) begin bad++; $display("FAIL sat_cnt2 cnt=%0d want 3", stall_cnt2); end
`ifdef HAZARD_FWD_EN
        total++; if (stall_cnt !== 16'd5) begin bad++; $display("FAIL sat_cnt16 cnt=%0d want 5", stall_cnt); end
`else
        total++; if (stall_cnt !== 16'd10) begin bad++; $display("FAIL sat_cnt16 cnt=%0d want 10", stall_cnt); end
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rand_inputs(3);
            #1; evaluate();
            total++; if (fwd_sel !== exp_fwd || fwd_sel2 !== exp_fwd) begin bad++; $display("FAIL rnd_fwd c=%0d fwd=%b fwd2=%b want %b", c, fwd_sel, fwd_sel2, exp_fwd); end
            total++; if (hazard_stall !== exp_stall || hazard_stall2 !== exp_stall) begin bad++; $display("FAIL rnd_stall c=%0d stall=%b stall2=%b want %b", c, hazard_stall, hazard_stall2, exp_stall); end
            total++; if (stall_cnt !== exp_cnt || stall_cnt2 !== exp_cnt2) begin bad++; $display("FAIL rnd_cnt c=%0d cnt=%0d cnt2=%0d want %0d/%0d", c, stall_cnt, stall_cnt2, exp_cnt, exp_cnt2); end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) st[i] = '0;
        #2 rst = 1'b0;
        test_reset();
        test_forward();
        test_mem_priority();
        test_load_use();
        test_flush();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
